// File: rtl/arb_mux_pkg.sv
// Shared definitions for arb_mux: mode encodings and circular index helper.
// Optional lock feature is enabled with ARB_MUX_LOCK_EN (see arb_mux.sv).
package arb_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  function automatic int unsigned circ_next(input int unsigned i, input int unsigned ch);
    return (i + 1) % ch;
  endfunction

endpackage

// File: rtl/arb_mux_rr_pick.sv
// Combinational circular priority encoder: first request at or after ptr,
// wrapping CH-1 -> 0.
module rr_pick
  import arb_mux_pkg::*;
#(
  parameter int unsigned CH   = 4,
  parameter int unsigned SELW = 2
) (
  input  logic [CH-1:0]   req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_vld
);

  logic [2*CH-1:0] scan;
  int unsigned     pos;

  // Rotating a doubled request vector puts request ptr at bit 0.
  always_comb begin
    scan    = {req, req} >> ptr;
    pos     = 0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int unsigned k = 0; k < CH; k++) begin
      if (!gnt_vld && scan[0]) begin
        pos = 32'(ptr) + k;
        if (pos >= CH) pos = pos - CH;
        gnt_idx = pos[SELW-1:0];
        gnt_vld = 1'b1;
      end
      scan = scan >> 1;
    end
  end

endmodule

// File: rtl/arb_mux.sv
// Registered CH-way valid/ready multiplexer with fixed-select and round-robin modes.
// Define ARB_MUX_LOCK_EN to add the in_lock port and locked round-robin bursts.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int unsigned N    = 5,
  parameter int unsigned CH   = 4,
  parameter int unsigned SELW = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH*N-1:0] in_data,
  input  logic [CH-1:0]   in_valid,
  output logic [CH-1:0]   in_ready,
`ifdef ARB_MUX_LOCK_EN
  input  logic [CH-1:0]   in_lock,
`endif
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  output logic [N-1:0]    out_data,
  output logic [SELW-1:0] out_ch,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [N-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_ch_q, out_ch_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
`ifdef ARB_MUX_LOCK_EN
  logic            locked_q, locked_d;
  logic [SELW-1:0] lock_ch_q, lock_ch_d;
  logic [CH-1:0]   lock_bits;
`endif

  logic [CH-1:0]   rr_req;
  logic [SELW-1:0] rr_idx;
  logic            rr_vld;
  logic            free, fix_vld, gnt_vld, accept;
  logic [SELW-1:0] gnt_idx;
  logic [CH-1:0]   fix_bits;
  logic [CH*N-1:0] data_sh;
  logic [N-1:0]    gnt_data;

  always_comb begin
`ifdef ARB_MUX_LOCK_EN
    rr_req = locked_q ? (in_valid & (CH'(1) << lock_ch_q)) : in_valid;
`else
    rr_req = in_valid;
`endif
  end

  rr_pick #(
    .CH   (CH),
    .SELW (SELW)
  ) u_rr_pick (
    .req     (rr_req),
    .ptr     (rr_ptr_q),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  always_comb begin
    free     = !out_valid_q || out_ready;
    fix_bits = in_valid >> sel;
    fix_vld  = (32'(sel) < CH) && fix_bits[0];
    if (mode == MODE_RR) begin
      gnt_vld = rr_vld;
      gnt_idx = rr_idx;
    end else begin
      gnt_vld = fix_vld;
      gnt_idx = sel;
    end
    accept   = gnt_vld && free && !rst;
    in_ready = accept ? (CH'(1) << gnt_idx) : '0;
    data_sh  = in_data >> (32'(gnt_idx) * N);
    gnt_data = data_sh[N-1:0];
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef ARB_MUX_LOCK_EN
    locked_d    = locked_q;
    lock_ch_d   = lock_ch_q;
    lock_bits   = in_lock >> gnt_idx;
`endif
    if (accept) begin
      out_data_d  = gnt_data;
      out_ch_d    = gnt_idx;
      out_valid_d = 1'b1;
      if (mode == MODE_RR) begin
`ifdef ARB_MUX_LOCK_EN
        // Pointer is frozen for the whole burst and resumes after the locked channel.
        if (locked_q) begin
          if (!lock_bits[0]) begin
            locked_d = 1'b0;
            rr_ptr_d = SELW'(circ_next(32'(lock_ch_q), CH));
          end
        end else if (lock_bits[0]) begin
          locked_d  = 1'b1;
          lock_ch_d = gnt_idx;
        end else begin
          rr_ptr_d = SELW'(circ_next(32'(gnt_idx), CH));
        end
`else
        rr_ptr_d = SELW'(circ_next(32'(gnt_idx), CH));
`endif
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
`ifdef ARB_MUX_LOCK_EN
      locked_q    <= 1'b0;
      lock_ch_q   <= '0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef ARB_MUX_LOCK_EN
      locked_q    <= locked_d;
      lock_ch_q   <= lock_ch_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: directed vectors plus a per-cycle reference model.
// Lock scenario is exercised when ARB_MUX_LOCK_EN is defined.
module tb_arb_mux;
  import arb_mux_pkg::*;

  localparam int unsigned N    = 5;
  localparam int unsigned CH   = 4;
  localparam int unsigned SELW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH*N-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic            mode;
  logic [SELW-1:0] sel;
  logic [N-1:0]    out_data;
  logic [SELW-1:0] out_ch;
  logic            out_valid;
  logic            out_ready;
`ifdef ARB_MUX_LOCK_EN
  logic [CH-1:0]   in_lock;
`endif

  int vectors     = 0;
  int miscompares = 0;

  arb_mux #(.N(N), .CH(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef ARB_MUX_LOCK_EN
    .in_lock   (in_lock),
`endif
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: output register contents, arbitration pointer, lock.
  logic        m_valid   = 1'b0;
  logic [N-1:0] m_data   = '0;
  int unsigned m_ch      = 0;
  int unsigned m_ptr     = 0;
  bit          m_locked  = 1'b0;
  int unsigned m_lock_ch = 0;

  function automatic bit in_bit(input logic [CH-1:0] v, input int unsigned i);
    logic [CH-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [N-1:0] chan_data(input int unsigned g);
    logic [CH*N-1:0] t;
    t = in_data >> (g * N);
    return t[N-1:0];
  endfunction

  function automatic void model_grant(output bit v, output int unsigned g);
    v = 1'b0;
    g = 0;
    if (mode == 1'b0) begin
      if (sel < CH && in_bit(in_valid, sel)) begin v = 1'b1; g = sel; end
    end else if (m_locked) begin
      if (in_bit(in_valid, m_lock_ch)) begin v = 1'b1; g = m_lock_ch; end
    end else begin
      for (int unsigned k = 0; k < CH; k++) begin
        int unsigned c;
        c = (m_ptr + k) % CH;
        if (!v && in_bit(in_valid, c)) begin v = 1'b1; g = c; end
      end
    end
  endfunction

  bit          u_v;
  int unsigned u_g;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0; m_locked = 1'b0; m_lock_ch = 0;
    end else begin
      model_grant(u_v, u_g);
      if (u_v && (!m_valid || out_ready)) begin
        m_valid = 1'b1;
        m_data  = chan_data(u_g);
        m_ch    = u_g;
        if (mode == 1'b1) begin
`ifdef ARB_MUX_LOCK_EN
          if (m_locked) begin
            if (!in_bit(in_lock, u_g)) begin m_locked = 1'b0; m_ptr = (m_lock_ch + 1) % CH; end
          end else if (in_bit(in_lock, u_g)) begin
            m_locked = 1'b1; m_lock_ch = u_g;
          end else begin
            m_ptr = (u_g + 1) % CH;
          end
`else
          m_ptr = (u_g + 1) % CH;
`endif
        end
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  bit            c_v;
  int unsigned   c_g;
  logic [CH-1:0] c_rdy;
  always @(negedge clk) begin
    model_grant(c_v, c_g);
    c_rdy = (!rst && c_v && (!m_valid || out_ready)) ? (CH'(1) << c_g) : '0;
    check("model_in_ready", 32'(in_ready), 32'(c_rdy));
    check("model_out_valid", 32'(out_valid), 32'(m_valid));
    check("model_out_data", 32'(out_data), 32'(m_data));
    check("model_out_ch", 32'(out_ch), m_ch);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int unsigned ch, input logic [N-1:0] d);
    in_data[ch*N +: N] = d;
  endtask

  int unsigned rr_seq[6] = '{0, 1, 2, 3, 0, 1};
`ifdef ARB_MUX_LOCK_EN
  logic [CH-1:0] lock_pat[4] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000};
  int unsigned   lock_exp[4] = '{1, 1, 1, 2};
`else
  int unsigned   lock_exp[4] = '{1, 2, 1, 2};
`endif

  typedef struct {
    logic            m;
    logic [SELW-1:0] s;
    logic [CH-1:0]   v;
    logic            r;
  } row_t;
  row_t rows[8] = '{
    '{1'b1, 2'd0, 4'b1010, 1'b1}, '{1'b1, 2'd0, 4'b1010, 1'b0},
    '{1'b0, 2'd3, 4'b1000, 1'b1}, '{1'b0, 2'd0, 4'b1000, 1'b1},
    '{1'b1, 2'd1, 4'b0001, 1'b1}, '{1'b1, 2'd1, 4'b1111, 1'b0},
    '{1'b1, 2'd2, 4'b1100, 1'b1}, '{1'b0, 2'd1, 4'b0000, 1'b1}
  };

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b1;
`ifdef ARB_MUX_LOCK_EN
    in_lock = '0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fixed select
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0110;
    set_data(1, 5'h0A); set_data(2, 5'h15);
    #1 check("fix_ready", 32'(in_ready), 32'(4'b0100));
    tick();
    check("fix_valid", 32'(out_valid), 1);
    check("fix_data", 32'(out_data), 32'h15);
    check("fix_ch", 32'(out_ch), 2);
    sel = 2'd3;
    #1 check("fix_nogrant", 32'(in_ready), 0);
    tick();
    check("fix_drain", 32'(out_valid), 0);
    check("fix_hold_data", 32'(out_data), 32'h15);

    // Round-robin fairness
    mode = 1'b1; in_valid = 4'b1111;
    for (int unsigned i = 0; i < CH; i++) set_data(i, N'(5'h10 + i));
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr_ch", 32'(out_ch), rr_seq[i]);
      check("rr_data", 32'(out_data), 32'h10 + rr_seq[i]);
      check("rr_valid", 32'(out_valid), 1);
    end

    // Backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_ready", 32'(in_ready), 0);
      tick();
      check("bp_ch", 32'(out_ch), 1);
      check("bp_data", 32'(out_data), 32'h11);
      check("bp_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1 check("bp_resume_ready", 32'(in_ready), 32'(4'b0100));
    tick();
    check("bp_resume_ch", 32'(out_ch), 2);
    check("bp_resume_data", 32'(out_data), 32'h12);

    // Wrap with sparse requests, pointer at 3
    in_valid = 4'b0101;
    #1 check("wrap_ready0", 32'(in_ready), 32'(4'b0001));
    tick();
    check("wrap_ch0", 32'(out_ch), 0);
    #1 check("wrap_ready2", 32'(in_ready), 32'(4'b0100));
    tick();
    check("wrap_ch2", 32'(out_ch), 2);

    // Asynchronous reset while holding a beat
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; set_data(1, 5'h1F);
    tick();
    out_ready = 1'b0;
    tick();
    check("pre_rst_data", 32'(out_data), 32'h1F);
    check("pre_rst_valid", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    #1 check("restart_ready", 32'(in_ready), 32'(4'b0001));
    tick();
    check("restart_ch", 32'(out_ch), 0);

    // Channel 1 burst competing with channel 2
    in_valid = 4'b0110;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_MUX_LOCK_EN
      in_lock = lock_pat[i];
`endif
      tick();
      check("burst_ch", 32'(out_ch), lock_exp[i]);
    end
`ifdef ARB_MUX_LOCK_EN
    in_lock = '0;
`endif

    // Mixed rows checked by the model
    for (int i = 0; i < 8; i++) begin
      mode = rows[i].m; sel = rows[i].s; in_valid = rows[i].v; out_ready = rows[i].r;
      tick();
    end
    in_valid = '0; out_ready = 1'b1;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
